instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage with IF/ID pipeline register. Owns the program counter, issues word fetches to instruction memory over a request/ready handshake, and presents the fetched word plus PC+4 to the decode controller one cycle after memory accepts. Honours decode-stage stalls through a one-entry hold buffer and squashes in-flight work on a branch/jump redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- Clk  in  1  sole clock, rising edge
- Rst  in  1  reset; one clock; reset is synchronous and active-low
- Stall  in  1  decode cannot accept; IF/ID must hold
- PCSrc  in  1  redirect request from branch/jump resolution
- BranchTarget  in  32  redirect address; bits [1:0] ignored (forced 0)
- ImemReq  out  1  fetch request, combinational from state
- ImemAddr  out  32  word address of request (= PC)
- ImemReady  in  1  memory accepts request; ImemData valid same cycle
- ImemData  in  32  fetched instruction word
- Instruction  out  32  IF/ID instruction to controller; NOP (32'h0) when invalid
- PCPlus4  out  32  IF/ID PC+4 of Instruction
- InstrValid  out  1  IF/ID holds a real instruction

## Operation
- States: FETCH (ImemReq=1), HOLD (ImemReq=0, one word buffered).
- Accept event: FETCH and ImemReady=1 and PCSrc=0. On accept PC <= PC+4.
- FETCH, accept, Stall=0: IF/ID <= {ImemData, PC+4, valid=1}; stay FETCH.
- FETCH, accept, Stall=1: hold buffer <= {ImemData, PC+4}; IF/ID unchanged; -> HOLD.
- FETCH, no accept, Stall=0: IF/ID <= bubble {32'h0, PCPlus4 unchanged, valid=0}.
- FETCH, no accept, Stall=1: IF/ID unchanged.
- HOLD, Stall=1: everything unchanged.
- HOLD, Stall=0: IF/ID <= hold buffer, valid=1; -> FETCH.
- PCSrc=1 (any state, priority over Stall and ImemReady): PC <= {BranchTarget[31:2],2'b00}; IF/ID <= bubble; hold buffer discarded; -> FETCH. Any ImemData returned that cycle is dropped and PC does not also increment.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (Rst=0 at a rising edge): PC=RESET_PC, state=FETCH, Instruction=32'h0, PCPlus4=32'h0, InstrValid=0, hold buffer cleared. ImemReq forced 0 while Rst=0; first request in first cycle with Rst=1.
- Reset mid-operation overrides PCSrc, Stall, and a pending accept; no partial state survives.
- Fetch latency: accept at edge N (Stall=0) -> Instruction/InstrValid visible after edge N, i.e. consumed by controller in cycle N+1.
- Zero-wait memory sustains one instruction per cycle.
- ImemAddr stable while ImemReq=1 and ImemReady=0.
- Stall release from HOLD costs no extra cycle: buffered word enters IF/ID at release edge; next fetch issues the following cycle.
- Redirect penalty: target requested the cycle after PCSrc edge; first target instruction in IF/ID earliest two edges after PCSrc.

## Structure
- Shared package: instruction width (32), NOP word (32'h0), state encoding {FETCH, HOLD}, default RESET_PC.
- One sub-module: if_id_register (load/flush/hold controls, Instruction/PCPlus4/InstrValid storage); PC, hold buffer and FSM stay in instruction_fetch.

## Test plan
- Reset then ImemReady=1 constantly, ImemData=PC-derived -> ImemAddr 0,4,8,C on consecutive cycles; Instruction follows one cycle later, InstrValid=1, PCPlus4 4,8,C,10.
- ImemReady low 3 cycles at PC=8 -> ImemAddr held at 8, InstrValid=0 and Instruction=0 for 3 cycles, then word from 8 with PCPlus4=C.
- Stall=1 for 4 cycles while accept at PC=10 -> IF/ID holds prior word, ImemReq=0 after accept; on release Instruction=word@10, then ImemAddr=14.
- PCSrc=1, BranchTarget=32'h0000_0103 during accept at PC=20 (and while in HOLD) -> word@20 dropped, InstrValid=0, next ImemAddr=32'h100.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4 wraps to 0.
- Rst=0 asserted during HOLD with Stall=1 -> next cycle all outputs at reset values, ImemReq=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, the NOP
// word, the fetch FSM encoding and the default reset PC.
package instruction_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FETCH: a request is on the bus. HOLD: one fetched word is parked
    // in the hold buffer waiting for decode to drop its stall.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // Instruction addresses are word aligned; the low two bits of any
    // incoming redirect are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Holds the instruction, its PC+4 and a valid
// flag. Flush inserts a bubble (NOP, invalid) while keeping PC+4; load
// captures a new word; otherwise the contents are held.
module if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [31:0]        load_pcplus4,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pcplus4,
    output logic               valid
);

    // Pipeline register with synchronous reset; flush wins over load.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            instr   <= NOP;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= NOP;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= load_instr;
            pcplus4 <= load_pcplus4;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage. Owns the PC and the fetch FSM, issues word
// requests to instruction memory, parks one word in a hold buffer while
// decode stalls, and squashes in-flight work on a redirect.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               PCSrc,
    input  logic [31:0]        BranchTarget,
    output logic               ImemReq,
    output logic [31:0]        ImemAddr,
    input  logic               ImemReady,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] Instruction,
    output logic [31:0]        PCPlus4,
    output logic               InstrValid
);

    fetch_state_t       state, state_next;
    logic [31:0]        pc, pc_next, pc_plus4;
    logic [INSTR_W-1:0] hold_instr;
    logic [31:0]        hold_pcplus4;
    logic               hold_load, hold_clear;
    logic               accept;
    logic               ifid_load, ifid_flush;
    logic [INSTR_W-1:0] ifid_instr;
    logic [31:0]        ifid_pcplus4;

    assign pc_plus4 = pc + 32'd4;
    assign ImemAddr = pc;
    // No request leaves the stage while reset is held.
    assign ImemReq  = Rst && (state == FETCH);
    // A redirect drops whatever memory returns in the same cycle.
    assign accept   = (state == FETCH) && ImemReady && !PCSrc;

    // Next-state, next-PC and IF/ID / hold-buffer controls.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned and no latch is inferred.
        state_next   = state;
        pc_next      = pc;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr   = ImemData;
        ifid_pcplus4 = pc_plus4;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;

        if (PCSrc) begin
            pc_next    = word_align(BranchTarget);
            ifid_flush = 1'b1;
            hold_clear = 1'b1;
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc_next = pc_plus4;
                        if (Stall) begin
                            hold_load  = 1'b1;
                            state_next = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!Stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        ifid_load    = 1'b1;
                        ifid_instr   = hold_instr;
                        ifid_pcplus4 = hold_pcplus4;
                        state_next   = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // FSM state, PC and hold buffer; reset overrides every other input.
    always_ff @(posedge Clk) begin
        // NOTE: the hold buffer is a single entry, not a memory array, so
        // it is reset along with the rest of the state.
        if (!Rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            hold_instr   <= NOP;
            hold_pcplus4 <= 32'h0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (hold_clear) begin
                hold_instr   <= NOP;
                hold_pcplus4 <= 32'h0;
            end else if (hold_load) begin
                hold_instr   <= ImemData;
                hold_pcplus4 <= pc_plus4;
            end
        end
    end

    if_id_register u_if_id (
        .clk          (Clk),
        .rst_n        (Rst),
        .load         (ifid_load),
        .flush        (ifid_flush),
        .load_instr   (ifid_instr),
        .load_pcplus4 (ifid_pcplus4),
        .instr        (Instruction),
        .pcplus4      (PCPlus4),
        .valid        (InstrValid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch. Two instances share control inputs:
// dut 0 resets to 0, dut 1 resets to FFFF_FFF8 to exercise PC wrap.
// A transaction-level model (PC, queue-based hold buffer, IF/ID record)
// predicts every output.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Rst, Stall, PCSrc, ImemReady;
    logic [31:0] BranchTarget;
    logic [31:0] ImemData    [2];
    logic        ImemReq     [2];
    logic [31:0] ImemAddr    [2];
    logic [31:0] Instruction [2];
    logic [31:0] PCPlus4     [2];
    logic        InstrValid  [2];

    always #5 Clk = ~Clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .ImemReq(ImemReq[0]),
        .ImemAddr(ImemAddr[0]), .ImemReady(ImemReady),
        .ImemData(ImemData[0]), .Instruction(Instruction[0]),
        .PCPlus4(PCPlus4[0]), .InstrValid(InstrValid[0])
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .ImemReq(ImemReq[1]),
        .ImemAddr(ImemAddr[1]), .ImemReady(ImemReady),
        .ImemData(ImemData[1]), .Instruction(Instruction[1]),
        .PCPlus4(PCPlus4[1]), .InstrValid(InstrValid[1])
    );

    // Reference model state.
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4   [2];
    logic        m_valid [2];
    ent_t        hold_q  [2][$];
    bit          known = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    function automatic logic [31:0] reset_pc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    // One clock: drive inputs, check request side before the edge, advance
    // the model at the edge, check IF/ID after the edge.
    task automatic step(input logic rst, input logic stall, input logic pcsrc,
                        input logic ready, input logic [31:0] target);
        logic exp_req;
        ent_t e;
        Rst = rst; Stall = stall; PCSrc = pcsrc; ImemReady = ready;
        BranchTarget = target;
        for (int i = 0; i < 2; i++)
            ImemData[i] = known ? mem_word(m_pc[i]) : $urandom;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_req = rst && known && (hold_q[i].size() == 0);
            if (known || !rst) begin
                vectors++;
                if (ImemReq[i] !== exp_req) begin
                    miscompares++;
                    $display("FAIL dut%0d cyc%0d ImemReq: got %b exp %b", i, cyc, ImemReq[i], exp_req);
                end
            end
            if (exp_req) begin
                vectors++;
                if (ImemAddr[i] !== m_pc[i]) begin
                    miscompares++;
                    $display("FAIL dut%0d cyc%0d ImemAddr: got %h exp %h", i, cyc, ImemAddr[i], m_pc[i]);
                end
            end
        end
        @(posedge Clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_pc[i] = reset_pc(i);
                hold_q[i].delete();
                m_instr[i] = 32'h0; m_pc4[i] = 32'h0; m_valid[i] = 1'b0;
            end else if (pcsrc) begin
                m_pc[i] = {target[31:2], 2'b00};
                hold_q[i].delete();
                m_instr[i] = 32'h0; m_valid[i] = 1'b0;
            end else if (hold_q[i].size() != 0) begin
                if (!stall) begin
                    e = hold_q[i].pop_front();
                    m_instr[i] = e.instr; m_pc4[i] = e.pc4; m_valid[i] = 1'b1;
                end
            end else if (ready) begin
                e = {ImemData[i], m_pc[i] + 32'd4};
                m_pc[i] = m_pc[i] + 32'd4;
                if (stall) hold_q[i].push_back(e);
                else begin
                    m_instr[i] = e.instr; m_pc4[i] = e.pc4; m_valid[i] = 1'b1;
                end
            end else if (!stall) begin
                m_instr[i] = 32'h0; m_valid[i] = 1'b0;
            end
        end
        if (!rst) known = 1'b1;
        #1;
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                vectors += 3;
                if (Instruction[i] !== m_instr[i]) begin
                    miscompares++;
                    $display("FAIL dut%0d cyc%0d Instruction: got %h exp %h", i, cyc, Instruction[i], m_instr[i]);
                end
                if (PCPlus4[i] !== m_pc4[i]) begin
                    miscompares++;
                    $display("FAIL dut%0d cyc%0d PCPlus4: got %h exp %h", i, cyc, PCPlus4[i], m_pc4[i]);
                end
                if (InstrValid[i] !== m_valid[i]) begin
                    miscompares++;
                    $display("FAIL dut%0d cyc%0d InstrValid: got %b exp %b", i, cyc, InstrValid[i], m_valid[i]);
                end
            end
        end
        @(negedge Clk);
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        #1;
        vectors++;
        if (ImemReq[0] !== 1'b0 || InstrValid[0] !== 1'b0 ||
            Instruction[0] !== 32'h0 || PCPlus4[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got req=%b valid=%b instr=%h pc4=%h exp all zero",
                     ImemReq[0], InstrValid[0], Instruction[0], PCPlus4[0]);
        end
    endtask

    task automatic test_stream();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        vectors++;
        if (Instruction[0] !== mem_word(32'h4) || PCPlus4[0] !== 32'h8) begin
            miscompares++;
            $display("FAIL stream_word4: got %h/%h exp %h/00000008", Instruction[0], PCPlus4[0], mem_word(32'h4));
        end
        vectors++;
        if (PCPlus4[1] !== 32'h0 || ImemAddr[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got pc4=%h addr=%h exp 00000000/00000000", PCPlus4[1], ImemAddr[1]);
        end
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            vectors++;
            if (ImemAddr[0] !== 32'h8 || InstrValid[0] !== 1'b0 || Instruction[0] !== 32'h0) begin
                miscompares++;
                $display("FAIL wait_hold: got addr=%h valid=%b instr=%h exp 00000008/0/00000000",
                         ImemAddr[0], InstrValid[0], Instruction[0]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        vectors++;
        if (Instruction[0] !== mem_word(32'h8) || PCPlus4[0] !== 32'hC || InstrValid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_release: got %h/%h exp %h/0000000c", Instruction[0], PCPlus4[0], mem_word(32'h8));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
            vectors++;
            if (ImemReq[0] !== 1'b0 || Instruction[0] !== mem_word(32'hC)) begin
                miscompares++;
                $display("FAIL stall_hold: got req=%b instr=%h exp 0/%h", ImemReq[0], Instruction[0], mem_word(32'hC));
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        vectors++;
        if (Instruction[0] !== mem_word(32'h10) || PCPlus4[0] !== 32'h14 || ImemAddr[0] !== 32'h14) begin
            miscompares++;
            $display("FAIL stall_release: got %h/%h addr=%h exp %h/00000014 addr=00000014",
                     Instruction[0], PCPlus4[0], ImemAddr[0], mem_word(32'h10));
        end
    endtask

    task automatic test_redirect();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        vectors++;
        if (InstrValid[0] !== 1'b0 || ImemAddr[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_fetch: got valid=%b addr=%h exp 0/00000100", InstrValid[0], ImemAddr[0]);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0207);
        vectors++;
        if (InstrValid[0] !== 1'b0 || ImemReq[0] !== 1'b1 || ImemAddr[0] !== 32'h204) begin
            miscompares++;
            $display("FAIL redirect_hold: got valid=%b req=%b addr=%h exp 0/1/00000204",
                     InstrValid[0], ImemReq[0], ImemAddr[0]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_reset_in_hold();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
        vectors++;
        if (ImemReq[0] !== 1'b0 || InstrValid[0] !== 1'b0 ||
            Instruction[0] !== 32'h0 || PCPlus4[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_in_hold: got req=%b valid=%b instr=%h pc4=%h exp all zero",
                     ImemReq[0], InstrValid[0], Instruction[0], PCPlus4[0]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        vectors++;
        if (Instruction[0] !== mem_word(32'h0) || PCPlus4[0] !== 32'h4) begin
            miscompares++;
            $display("FAIL restart: got %h/%h exp %h/00000004", Instruction[0], PCPlus4[0], mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), $urandom);
    endtask

    initial begin
        Rst = 1'b0; Stall = 1'b0; PCSrc = 1'b0; ImemReady = 1'b0;
        BranchTarget = 32'h0;
        ImemData[0] = 32'h0; ImemData[1] = 32'h0;
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_redirect();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
